// File: rtl/spec_avg_pkg.sv
// Shared types and sizing helpers for the power-spectrum averager.
package spec_avg_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DUMP} state_t;

  function automatic int acc_width(input int pwr_w, input int max_log2);
    return pwr_w + max_log2;
  endfunction

  // Frame counter must hold 2^max_log2 itself.
  function automatic int cnt_width(input int max_log2);
    return max_log2 + 1;
  endfunction

  function automatic logic [2:0] clamp_log2(input logic [2:0] v, input int max_log2);
    return (int'(v) > max_log2) ? 3'(max_log2) : v;
  endfunction

endpackage

// File: rtl/spec_avg_ram.sv
// Simple dual-port RAM, registered read, no reset on contents (block-RAM friendly).
module spec_avg_ram #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13,
  parameter int DW    = 38
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spec_avg.sv
// Power-spectrum averager: accumulates 2^avg_log2 frames of |X|^2 in RAM,
// then streams the averaged frame out through a 2-entry skid buffer.
module spec_avg import spec_avg_pkg::*; #(
  parameter int IN_W         = 16,
  parameter int ADDR_W       = 13,
  parameter int FRAME_LEN    = 8192,
  parameter int MAX_AVG_LOG2 = 6,
  parameter int PWR_W        = 2*IN_W,
  parameter int ACC_W        = acc_width(PWR_W, MAX_AVG_LOG2)
) (
  input  logic                   fft_clk,
  input  logic                   reset_n,
  input  logic [2:0]             avg_log2,
  input  logic signed [IN_W-1:0] sink_real,
  input  logic signed [IN_W-1:0] sink_imag,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  output logic                   sink_ready,
  output logic [PWR_W-1:0]       source_data,
  output logic                   source_valid,
  output logic                   source_sop,
  output logic                   source_eop,
  output logic [1:0]             source_empty,
  input  logic                   source_ready,
  output logic                   frame_err
);

  localparam int CNT_W = cnt_width(MAX_AVG_LOG2);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN-1);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] bin_cnt, eff_bin;
  logic [CNT_W-1:0]  frame_cnt, target;
  logic [2:0]        avg_lat;
  logic              flush_cnt;
  logic              beat, err, restart, first, frame_done, last_frame;

  // Exact power: sign-extend before squaring; the sum only fits as unsigned.
  logic signed [PWR_W-1:0] re_x, im_x, re_sq, im_sq;
  logic [PWR_W-1:0]        pwr;
  assign re_x  = PWR_W'(sink_real);
  assign im_x  = PWR_W'(sink_imag);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pwr   = $unsigned(re_sq) + $unsigned(im_sq);

  // A sop beat is always treated as bin 0; any framing violation is an error.
  always_comb begin
    eff_bin    = sink_sop ? '0 : bin_cnt;
    beat       = sink_valid && sink_ready && (state == ACCUM || sink_sop);
    err        = beat && ((sink_sop && state == ACCUM && bin_cnt != '0) ||
                          (sink_eop != (eff_bin == LAST)));
    restart    = beat && sink_sop && (state == IDLE || err);
    first      = restart || frame_cnt == '0;
    frame_done = beat && !err && sink_eop;
    target     = CNT_W'(1) << avg_lat;
    last_frame = frame_done && (frame_cnt + 1'b1 == target);
  end

  // Write pipeline: stage 1 holds the power while RAM[b] is read.
  logic              s1_vld, s1_first;
  logic [ADDR_W-1:0] s1_addr;
  logic [PWR_W-1:0]  s1_pwr;
  logic [ACC_W-1:0]  rdata, wdata;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;

  assign wdata = s1_first ? ACC_W'(s1_pwr) : rdata + ACC_W'(s1_pwr);

  // Dump read side and skid buffer.
  logic [ADDR_W-1:0] rd_addr, pend_addr;
  logic              rd_done, rd_pend, issue, pop, dump_end;
  logic [PWR_W-1:0]  f_data [2];
  logic [1:0]        f_sop, f_eop, f_cnt;
  logic              wp, rp;

  assign source_valid = f_cnt != 2'd0;
  assign source_data  = f_data[rp];
  assign source_sop   = source_valid && f_sop[rp];
  assign source_eop   = source_valid && f_eop[rp];
  assign source_empty = 2'd0;
  assign pop          = source_valid && source_ready;
  assign dump_end     = pop && f_eop[rp];
  // Only issue a read if its data is guaranteed a slot even with no pop next cycle.
  assign issue        = state == DUMP && !rd_done &&
                        (int'(f_cnt) + int'(rd_pend) <= 1 + int'(pop));

  assign ram_re    = beat || issue;
  assign ram_raddr = (state == DUMP) ? rd_addr : eff_bin;

  spec_avg_ram #(.DEPTH(FRAME_LEN), .AW(ADDR_W), .DW(ACC_W)) u_ram (
    .clk   (fft_clk),
    .we    (s1_vld),
    .waddr (s1_addr),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (beat) state_nxt = ACCUM;
      ACCUM: begin
        if (err && !sink_sop) state_nxt = IDLE;
        else if (last_frame)  state_nxt = FLUSH;
      end
      FLUSH: if (flush_cnt) state_nxt = DUMP;
      DUMP:  if (dump_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sink_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      sink_ready <= (state_nxt == IDLE) || (state_nxt == ACCUM);
    end
  end

  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      avg_lat   <= '0;
      flush_cnt <= 1'b0;
      frame_err <= 1'b0;
      s1_vld    <= 1'b0;
      s1_first  <= 1'b0;
      s1_addr   <= '0;
      s1_pwr    <= '0;
    end else begin
      if (restart) avg_lat <= clamp_log2(avg_log2, MAX_AVG_LOG2);
      if (beat) bin_cnt <= ((err && !sink_sop) || frame_done) ? '0 : eff_bin + 1'b1;
      if (err || dump_end) frame_cnt <= '0;
      else if (frame_done) frame_cnt <= frame_cnt + 1'b1;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      frame_err <= frame_err | err;
      s1_vld    <= beat && (!err || sink_sop);
      s1_first  <= first;
      s1_addr   <= eff_bin;
      s1_pwr    <= pwr;
    end
  end

  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      pend_addr <= '0;
      rd_done   <= 1'b0;
      rd_pend   <= 1'b0;
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_sop     <= '0;
      f_eop     <= '0;
      f_cnt     <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        pend_addr <= rd_addr;
        if (rd_addr == LAST) rd_done <= 1'b1;
        else                 rd_addr <= rd_addr + 1'b1;
      end
      if (dump_end) begin
        rd_done <= 1'b0;
        rd_addr <= '0;
      end
      if (rd_pend) begin
        f_data[wp] <= PWR_W'(rdata >> avg_lat);
        f_sop[wp]  <= pend_addr == '0;
        f_eop[wp]  <= pend_addr == LAST;
        wp         <= ~wp;
      end
      if (pop) rp <= ~rp;
      f_cnt <= f_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spec_avg.sv
// Directed bench for spec_avg with an 8-bin frame.
module tb_spec_avg;

  localparam int IN_W = 16;
  localparam int FL   = 8;

  typedef int frame_t [FL];
  typedef logic [31:0] exp_t [FL];
  typedef struct {
    logic [2:0]  avg;
    int          nfr;
    int          re_a, im_a, re_b, im_b;
    logic [31:0] exp;
  } row_t;

  logic                   clk, reset_n;
  logic [2:0]             avg_log2;
  logic signed [IN_W-1:0] sink_real, sink_imag;
  logic                   sink_valid, sink_sop, sink_eop, sink_ready;
  logic [31:0]            source_data;
  logic                   source_valid, source_sop, source_eop, source_ready;
  logic [1:0]             source_empty;
  logic                   frame_err;

  int          checks = 0, failures = 0;
  logic [33:0] out_q [$];
  int          acc_qsize;
  logic        rnd_rdy = 1'b0;

  spec_avg #(.IN_W(IN_W), .ADDR_W(3), .FRAME_LEN(FL), .MAX_AVG_LOG2(6)) dut (
    .fft_clk(clk), .reset_n(reset_n), .avg_log2(avg_log2),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_empty(source_empty), .source_ready(source_ready),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pattern, changed just after each rising edge.
  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      source_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records transfers and checks stability while stalled.
  initial begin
    logic        stall;
    logic [34:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) stall = 1'b0;
      else begin
        if (stall)
          check("hold while stalled", {source_valid, source_sop, source_eop, source_data}, held);
        if (source_valid && source_ready) out_q.push_back({source_sop, source_eop, source_data});
        stall = source_valid && !source_ready;
        held  = {source_valid, source_sop, source_eop, source_data};
      end
    end
  end

  task automatic send_beat(input int re, input int im, input logic sop, input logic eop);
    logic rdy;
    int   t;
    t = 0;
    sink_real = IN_W'(re); sink_imag = IN_W'(im);
    sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
    do begin
      @(negedge clk); rdy = sink_ready;
      @(posedge clk); t++;
    end while (!rdy && t < 500);
    #1;
    acc_qsize  = out_q.size();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    if (!rdy) check("sink accept timeout", rdy, 1);
  endtask

  task automatic send_frame(input frame_t re, input frame_t im);
    for (int b = 0; b < FL; b++) send_beat(re[b], im[b], b == 0, b == FL-1);
  endtask

  task automatic send_uniform(input int re, input int im);
    frame_t r, i;
    for (int b = 0; b < FL; b++) begin r[b] = re; i[b] = im; end
    send_frame(r, i);
  endtask

  task automatic wait_out(input string name);
    int t;
    t = 0;
    while (out_q.size() < FL && t < 3000) begin @(posedge clk); t++; end
    repeat (12) @(posedge clk);
    #1;
    if (out_q.size() < FL) check({name, " timeout"}, out_q.size(), FL);
  endtask

  task automatic check_frame(input string name, input exp_t exp);
    check({name, " beat count"}, out_q.size(), FL);
    for (int i = 0; i < FL; i++)
      if (i < out_q.size())
        check(name, out_q[i], {i == 0, i == FL-1, exp[i]});
    out_q.delete();
  endtask

  row_t   tbl [4];
  frame_t ra, ia;
  exp_t   ex;

  initial begin
    tbl[0] = '{avg: 3'd1, nfr: 2,  re_a: -32768, im_a: -32768, re_b: 0,  im_b: 0, exp: 32'h4000_0000};
    tbl[1] = '{avg: 3'd7, nfr: 64, re_a: 1,      im_a: 2,      re_b: 10, im_b: 0, exp: 32'd52};
    tbl[2] = '{avg: 3'd1, nfr: 2,  re_a: 1,      im_a: 0,      re_b: 1,  im_b: 1, exp: 32'd1};
    tbl[3] = '{avg: 3'd0, nfr: 1,  re_a: -5,     im_a: 7,      re_b: 0,  im_b: 0, exp: 32'd74};

    reset_n = 1'b0; avg_log2 = '0; sink_real = '0; sink_imag = '0;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    #3;
    check("reset sink_ready", sink_ready, 0);
    check("reset source_valid", source_valid, 0);
    check("reset source_sop/eop", {source_sop, source_eop}, 0);
    check("reset source_data", source_data, 0);
    check("reset source_empty", source_empty, 0);
    check("reset frame_err", frame_err, 0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle sink_ready", sink_ready, 1);

    // Non-sop beat in IDLE is dropped silently.
    send_beat(5, 5, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("idle stray beat no err", frame_err, 0);

    // Ramp, single frame.
    avg_log2 = 3'd0;
    for (int k = 0; k < FL; k++) begin ra[k] = k; ia[k] = 0; ex[k] = 32'(k*k); end
    send_frame(ra, ia);
    wait_out("ramp");
    check("source_empty", source_empty, 0);
    check_frame("ramp", ex);

    // Uniform-frame runs.
    foreach (tbl[r]) begin
      avg_log2 = tbl[r].avg;
      for (int f = 0; f < tbl[r].nfr; f++)
        if (f % 2 == 0) send_uniform(tbl[r].re_a, tbl[r].im_a);
        else            send_uniform(tbl[r].re_b, tbl[r].im_b);
      wait_out($sformatf("row%0d", r));
      for (int k = 0; k < FL; k++) ex[k] = tbl[r].exp;
      check_frame($sformatf("row%0d", r), ex);
    end

    // Next frame offered during flush/dump is held off, then accepted.
    avg_log2 = 3'd2;
    repeat (4) send_uniform(3, 4);
    avg_log2 = 3'd0;
    send_beat(6, 8, 1'b1, 1'b0);
    check("holdoff until dump done", acc_qsize, FL);
    for (int b = 1; b < FL; b++) send_beat(6, 8, 1'b0, b == FL-1);
    for (int k = 0; k < FL; k++) ex[k] = 32'd25;
    check_frame("avg4 25", ex);
    wait_out("held frame");
    for (int k = 0; k < FL; k++) ex[k] = 32'd100;
    check_frame("held frame", ex);

    // Random backpressure during dump.
    rnd_rdy = 1'b1;
    for (int k = 0; k < FL; k++) begin ra[k] = 100*k; ia[k] = k; ex[k] = 32'(10001*k*k); end
    send_frame(ra, ia);
    wait_out("random ready");
    rnd_rdy = 1'b0;
    check_frame("random ready", ex);
    check("no err before malformed", frame_err, 0);

    // Sop injected at bin 3 of frame 1 restarts the run.
    avg_log2 = 3'd1;
    send_uniform(100, 0);
    send_beat(100, 0, 1'b1, 1'b0);
    send_beat(100, 0, 1'b0, 1'b0);
    send_beat(100, 0, 1'b0, 1'b0);
    send_uniform(2, 0);
    check("frame_err after sop at bin3", frame_err, 1);
    send_uniform(4, 0);
    wait_out("restart");
    for (int k = 0; k < FL; k++) ex[k] = 32'd10;
    check_frame("restart", ex);

    // Reset in the middle of a dump.
    avg_log2 = 3'd0;
    send_uniform(1000, 0);
    begin
      int t;
      t = 0;
      while (out_q.size() < 3 && t < 200) begin @(posedge clk); t++; end
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midreset source_valid", source_valid, 0);
    check("midreset source_data", source_data, 0);
    check("midreset sop/eop", {source_sop, source_eop}, 0);
    check("midreset sink_ready", sink_ready, 0);
    check("midreset frame_err", frame_err, 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    out_q.delete();
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < FL; k++) begin ra[k] = k; ia[k] = k; ex[k] = 32'(2*k*k); end
    send_frame(ra, ia);
    wait_out("post reset");
    check_frame("post reset", ex);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
